oem_reader: RTL

Read-back sequencer for the eight 32x8 odd/even memory banks filled by the serial data-arrange writer.
- On a start pulse it walks all 256 byte positions in raster order (32 rows x 8 columns).
- For each position it issues one read strobe plus an address to the correct bank.
- Returned bytes are streamed out on a valid/ready interface, throttled by a credit-controlled output FIFO.
- Sits downstream of the writer; its start is driven from the writer's finish flag.

---
 rtl/oem_reader_pkg.sv | 37 +++
 rtl/oem_reader_fifo.sv | 57 +++++
 rtl/oem_reader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/oem_reader_pkg.sv
// Shared types, sizes and the raster-index to bank/address decode used by
// the odd/even bank reader and by the writer's verification model.
package oem_reader_pkg;

    localparam int NUM_BYTES   = 256;
    localparam int BANK_GROUPS = 4;
    localparam int ADDR_W      = 5;
    localparam int DATA_W      = 8;
    localparam int IDX_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic              odd;
        logic [1:0]        group;
        logic [ADDR_W-1:0] addr;
    } bank_sel_t;

    // Raster index n = {row[4:0], col[2:0]}; the row/column parity picks odd vs even.
    function automatic bank_sel_t bank_decode(input logic [IDX_W-1:0] n);
        bank_sel_t  s;
        logic [4:0] r;
        logic [2:0] c;
        r       = n[7:3];
        c       = n[2:0];
        s.odd   = c[0] ^ r[0];
        s.group = r[4:3];
        s.addr  = {r[2:0], c[2:1]};
        return s;
    endfunction

endpackage

// File: rtl/oem_reader_fifo.sv
// Small synchronous FIFO buffering returned bank bytes ahead of the
// valid/ready output; depth must be a power of two.
module oem_reader_fifo
    import oem_reader_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Head reads as zero when empty so the output bus is quiet after reset.
    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/oem_reader.sv
// Read-back sequencer: walks 256 raster positions over the eight odd/even
// banks and streams the returned bytes through a credit-limited FIFO.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | issuing one read per cycle while credits remain
//   DRAIN | all reads issued, waiting for returns and FIFO to empty
//   DONE  | one-cycle done pulse
module oem_reader
    import oem_reader_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    output logic [BANK_GROUPS-1:0] odd_rd_o,
    output logic [BANK_GROUPS-1:0] even_rd_o,
    output logic [ADDR_W-1:0]      rd_addr_o,
    input  logic [DATA_W-1:0]      rd_data_i,
    output logic [DATA_W-1:0]      out_data_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   armed_q;
    logic [BANK_GROUPS-1:0] odd_rd_q, odd_rd_d, even_rd_q, even_rd_d;
    logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
    logic [RD_LAT-1:0]      vld_q, vld_d;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [SUM_W-1:0]       inflight, used;
    logic                   strobe_any, issue;
    bank_sel_t              sel;

    assign strobe_any = |{odd_rd_q, even_rd_q};

    // Reads in flight: the strobe on the bus this cycle plus the latency pipe.
    always_comb begin
        inflight = SUM_W'(strobe_any);
        for (int k = 0; k < RD_LAT; k++) begin
            inflight = inflight + SUM_W'(vld_q[k]);
        end
    end

    always_comb begin
        vld_d    = '0;
        vld_d[0] = strobe_any;
        for (int k = 1; k < RD_LAT; k++) begin
            vld_d[k] = vld_q[k-1];
        end
    end

    assign used      = SUM_W'(fifo_count) + inflight;
    assign issue     = (state_q == ST_RUN) && (used < SUM_W'(FIFO_DEPTH));
    assign fifo_push = vld_q[RD_LAT-1] && !fifo_full;
    assign fifo_pop  = out_valid_o && out_ready_i;
    assign sel       = bank_decode(idx_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        odd_rd_d  = '0;
        even_rd_d = '0;
        rd_addr_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && armed_q) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (issue) begin
                    if (sel.odd) odd_rd_d  = BANK_GROUPS'(1) << sel.group;
                    else         even_rd_d = BANK_GROUPS'(1) << sel.group;
                    rd_addr_d = sel.addr;
                    idx_d     = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NUM_BYTES - 1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave as the last byte is accepted so done lands the very next cycle.
                if (inflight == '0 &&
                    (fifo_empty || (fifo_count == CNT_W'(1) && fifo_pop))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            armed_q   <= 1'b0;
            odd_rd_q  <= '0;
            even_rd_q <= '0;
            rd_addr_q <= '0;
            vld_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            armed_q   <= 1'b1;
            odd_rd_q  <= odd_rd_d;
            even_rd_q <= even_rd_d;
            rd_addr_q <= rd_addr_d;
            vld_q     <= vld_d;
        end
    end

    oem_reader_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (fifo_push),
        .push_data_i (rd_data_i),
        .pop_i       (fifo_pop),
        .head_o      (out_data_o),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign out_valid_o = !fifo_empty;
    assign odd_rd_o    = odd_rd_q;
    assign even_rd_o   = even_rd_q;
    assign rd_addr_o   = rd_addr_q;
    assign busy_o      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done_o      = (state_q == ST_DONE);

endmodule
